seg_capture: RTL and testbench

- Receive end of the multiplexed 4-digit 7-segment display bus that the display driver produces.
- Samples the digit-enable lines and the active-low segment lines, and decodes each segment pattern back to a hex nibble plus a dot flag.
- Assembles the four digits into a 16-bit value and a 4-bit dot vector, then publishes one frame at a time with a valid pulse.
- Used for loopback self-test of the display path and for sniffing external multiplexed displays.

---
 rtl/seg_capture.sv | 170 +++++++++++++++++
 tb/tb_seg_capture.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// Receive side of a multiplexed 4-digit 7-segment bus: decodes digits back into a 16-bit frame.
// Optional SEG_CAPTURE_CHANGE_ONLY_EN publishes a completed frame only when it differs from the last.
module seg_capture #(
    parameter int unsigned SETTLE      = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  dig_in,
    output logic [15:0] value,
    output logic [3:0]  dots,
    output logic        valid,
    output logic        err
);
    localparam int unsigned CntW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    logic [7:0]  seg_sync [SYNC_STAGES];
    logic [3:0]  dig_sync [SYNC_STAGES];
    logic [3:0]  sd;
    logic [7:0]  ss;
    logic        onehot;
    logic        strobe;
    logic [1:0]  dig_idx;
    logic [4:0]  dec;
    logic [15:0] shadow_q;
    logic [3:0]  sdots_q;
    logic [3:0]  seen_q, seen_d;
    logic        bad_q, bad_d;
    logic        frame_done;
    logic        publish;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                seg_sync[i] <= 8'hFF;
                dig_sync[i] <= 4'h0;
            end
        end else begin
            seg_sync[0] <= seg_in;
            dig_sync[0] <= dig_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                seg_sync[i] <= seg_sync[i-1];
                dig_sync[i] <= dig_sync[i-1];
            end
        end
    end

    assign sd     = dig_sync[SYNC_STAGES-1];
    assign ss     = seg_sync[SYNC_STAGES-1];
    assign onehot = (sd != 4'h0) && ((sd & (sd - 4'h1)) == 4'h0);

    generate
        if (SETTLE == 0) begin : g_no_settle
            assign strobe = onehot;
        end else begin : g_settle
            logic [11:0]     prev_q;
            logic [CntW-1:0] cnt_q;
            logic            inc;

            assign inc    = onehot && ({sd, ss} == prev_q);
            // Counter saturates at SETTLE so a held pair strobes only once.
            assign strobe = inc && (cnt_q == CntW'(SETTLE - 1));

            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    prev_q <= {4'h0, 8'hFF};
                    cnt_q  <= '0;
                end else begin
                    prev_q <= {sd, ss};
                    if (!inc) begin
                        cnt_q <= '0;
                    end else if (cnt_q != CntW'(SETTLE)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // {miss, nibble}; a miss decodes as nibble 0.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    assign dec = decode(ss[6:0]);

    always_comb begin
        dig_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (sd[i]) dig_idx = 2'(i);
        end
    end

    assign frame_done = (seen_q == 4'hF);

    // A strobe in the publish cycle lands after the clear and starts the next frame.
    always_comb begin
        seen_d = frame_done ? 4'h0 : seen_q;
        bad_d  = frame_done ? 1'b0 : bad_q;
        if (strobe) begin
            seen_d[dig_idx] = 1'b1;
            bad_d           = bad_d | dec[4];
        end
    end

`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
    logic pub_once_q;

    assign publish = frame_done &&
                     (!pub_once_q || ({shadow_q, sdots_q, bad_q} != {value, dots, err}));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pub_once_q <= 1'b0;
        end else if (publish) begin
            pub_once_q <= 1'b1;
        end
    end
`else
    assign publish = frame_done;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            shadow_q <= 16'h0;
            sdots_q  <= 4'h0;
            seen_q   <= 4'h0;
            bad_q    <= 1'b0;
            value    <= 16'h0;
            dots     <= 4'h0;
            err      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            if (strobe) begin
                shadow_q[{dig_idx, 2'b00} +: 4] <= dec[3:0];
                sdots_q[dig_idx]                <= ~ss[7];
            end
            seen_q <= seen_d;
            bad_q  <= bad_d;
            valid  <= publish;
            if (publish) begin
                value <= shadow_q;
                dots  <= sdots_q;
                err   <= bad_q;
            end
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: DUT a (SETTLE=0, 2 sync stages), DUT b (SETTLE=3, 1 stage).
// Follows SEG_CAPTURE_CHANGE_ONLY_EN when defined.
module tb_seg_capture;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  seg_a, seg_b;
    logic [3:0]  dig_a, dig_b;
    logic [15:0] value_a, value_b;
    logic [3:0]  dots_a, dots_b;
    logic        valid_a, valid_b, err_a, err_b;

    int n_checks = 0;
    int n_fails  = 0;
    logic [20:0] exp_a[$];
    logic [20:0] exp_b[$];
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
    logic [20:0] last_pub[2];
    bit          first_pub[2];
`endif

    always #5 CLK = ~CLK;

    seg_capture #(.SETTLE(0), .SYNC_STAGES(2)) u_dut_a (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .seg_in (seg_a),
        .dig_in (dig_a),
        .value  (value_a),
        .dots   (dots_a),
        .valid  (valid_a),
        .err    (err_a)
    );

    seg_capture #(.SETTLE(3), .SYNC_STAGES(1)) u_dut_b (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .seg_in (seg_b),
        .dig_in (dig_b),
        .value  (value_b),
        .dots   (dots_b),
        .valid  (valid_b),
        .err    (err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_frame(input int b, input logic [20:0] act);
        logic [20:0] exp;
        n_checks++;
        if ((b == 0 && exp_a.size() == 0) || (b == 1 && exp_b.size() == 0)) begin
            n_fails++;
            $display("FAIL frame_%0d: unexpected valid with value=%h dots=%b err=%b, required none",
                     b, act[20:5], act[4:1], act[0]);
            return;
        end
        if (b == 0) exp = exp_a.pop_front();
        else        exp = exp_b.pop_front();
        if (act !== exp) begin
            n_fails++;
            $display("FAIL frame_%0d: got value=%h dots=%b err=%b, required value=%h dots=%b err=%b",
                     b, act[20:5], act[4:1], act[0], exp[20:5], exp[4:1], exp[0]);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N === 1'b1 && valid_a === 1'b1) check_frame(0, {value_a, dots_a, err_a});
    end

    always @(negedge CLK) begin
        if (RST_N === 1'b1 && valid_b === 1'b1) check_frame(1, {value_b, dots_b, err_b});
    end

    task automatic expect_frame(input int b, input logic [15:0] v, input logic [3:0] d,
                                input logic e);
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
        if (!first_pub[b] && last_pub[b] == {v, d, e}) return;
        first_pub[b] = 1'b0;
        last_pub[b]  = {v, d, e};
`endif
        if (b == 0) exp_a.push_back({v, d, e});
        else        exp_b.push_back({v, d, e});
    endtask

    task automatic drive(input int b, input logic [3:0] d, input logic [7:0] s, input int n);
        if (b == 0) begin
            dig_a = d;
            seg_a = s;
        end else begin
            dig_b = d;
            seg_b = s;
        end
        repeat (n) @(negedge CLK);
    endtask

    task automatic frame(input int b, input logic [7:0] s3, input logic [7:0] s2,
                         input logic [7:0] s1, input logic [7:0] s0, input int hold);
        drive(b, 4'b1000, s3, hold);
        drive(b, 4'b0100, s2, hold);
        drive(b, 4'b0010, s1, hold);
        drive(b, 4'b0001, s0, hold);
    endtask

    task automatic idle(input int b, input int n);
        drive(b, 4'b0000, 8'hFF, n);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_value_a"}, 32'(value_a), 32'h0);
        check({tag, "_dots_a"},  32'(dots_a),  32'h0);
        check({tag, "_valid_a"}, 32'(valid_a), 32'h0);
        check({tag, "_err_a"},   32'(err_a),   32'h0);
        check({tag, "_value_b"}, 32'(value_b), 32'h0);
        check({tag, "_valid_b"}, 32'(valid_b), 32'h0);
    endtask

    task automatic reset_model();
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
        first_pub = '{1'b1, 1'b1};
        last_pub  = '{21'h0, 21'h0};
`endif
    endtask

    task automatic do_reset(input int n);
        RST_N = 1'b0;
        repeat (n) begin
            @(negedge CLK);
            check_zero("mid_rst");
        end
        RST_N = 1'b1;
        reset_model();
    endtask

    initial begin
        RST_N = 1'b0;
        reset_model();
        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            seg_a = 8'($urandom);
            dig_a = 4'($urandom);
            seg_b = 8'($urandom);
            dig_b = 4'($urandom);
            @(negedge CLK);
            check_zero("rst");
        end
        dig_a = 4'h0; seg_a = 8'hFF;
        dig_b = 4'h0; seg_b = 8'hFF;
        RST_N = 1'b1;
        @(negedge CLK);
        check_zero("rst_release");

        // One cycle per digit, all dots lit: 1A2F
        for (int r = 0; r < 3; r++) begin
            expect_frame(0, 16'h1A2F, 4'b1111, 1'b0);
            frame(0, 8'h79, 8'h08, 8'h24, 8'h0E, 1);
        end
        idle(0, 8);

        // Blank digit 1 -> error frame, then a clean frame
        expect_frame(0, 16'h1204, 4'b0000, 1'b1);
        frame(0, 8'hF9, 8'hA4, 8'hFF, 8'h99, 1);
        idle(0, 6);
        expect_frame(0, 16'h1234, 4'b0000, 1'b0);
        frame(0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 1);
        idle(0, 6);

        // Multi-hot and zero enables must not complete a frame missing digit 0
        expect_frame(0, 16'h309B, 4'b0010, 1'b0);
        drive(0, 4'b1000, 8'hB0, 1);
        drive(0, 4'b0100, 8'hC0, 1);
        drive(0, 4'b0010, 8'h10, 1);
        drive(0, 4'b0011, 8'h80, 10);
        drive(0, 4'b0000, 8'h80, 10);
        drive(0, 4'b0001, 8'h83, 1);
        idle(0, 8);

        // Reset after two digits: the partial frame is discarded
        drive(0, 4'b1000, 8'h90, 1);
        drive(0, 4'b0100, 8'h80, 1);
        idle(0, 3);
        do_reset(2);
        idle(0, 2);
        drive(0, 4'b0010, 8'hF8, 1);
        drive(0, 4'b0001, 8'h82, 1);
        idle(0, 10);
        expect_frame(0, 16'h5C76, 4'b0000, 1'b0);
        drive(0, 4'b1000, 8'h92, 1);
        drive(0, 4'b0100, 8'hC6, 1);
        idle(0, 8);

        // Identical frames repeated
        for (int r = 0; r < 2; r++) begin
            expect_frame(0, 16'h5C76, 4'b0000, 1'b0);
            frame(0, 8'h92, 8'hC6, 8'hF8, 8'h82, 1);
            idle(0, 6);
        end

        // SETTLE=3: pairs stable 2 or 3 cycles never strobe
        for (int r = 0; r < 5; r++) frame(1, 8'hC0, 8'hF9, 8'hA4, 8'hB0, 2);
        for (int r = 0; r < 3; r++) frame(1, 8'hC0, 8'hF9, 8'hA4, 8'hB0, 3);
        idle(1, 4);

        // SETTLE=3: segments change after 2 cycles, then held; 4 cycles is the minimum hold
        expect_frame(1, 16'hEBDC, 4'b1010, 1'b0);
        drive(1, 4'b1000, 8'h00, 2);
        drive(1, 4'b1000, 8'h06, 6);
        drive(1, 4'b0100, 8'h83, 4);
        drive(1, 4'b0010, 8'h21, 4);
        drive(1, 4'b0001, 8'hC6, 26);
        idle(1, 10);

        check("pending_a", 32'(exp_a.size()), 32'h0);
        check("pending_b", 32'(exp_b.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
